// File: rtl/mealy_ctrl_multi.sv
// mealy_ctrl_multi
//   Multi-channel Mealy controller. Each channel runs an IDLE/ARMED/HOLD/LOCK
//   machine whose B1/B2 outputs are combinational in state and I/S. B2 is
//   stretched through HOLD by a per-channel down-counter. A shared saturating
//   counter tallies ARMED->HOLD entries across all channels.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   clear       synchronous clear, overrides every transition and the count
//   I, S        per-channel inputs
//   B1, B2      per-channel Mealy outputs (combinational)
//   state_o     channel c state at [2c+1:2c]
//   hold_events saturating count of ARMED->HOLD transitions
module mealy_ctrl_multi #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned HOLD_CYCLES = 5,
    parameter int unsigned HOLD_W      = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [CHANNELS-1:0]   I,
    input  logic [CHANNELS-1:0]   S,
    output logic [CHANNELS-1:0]   B1,
    output logic [CHANNELS-1:0]   B2,
    output logic [2*CHANNELS-1:0] state_o,
    output logic [CNT_W-1:0]      hold_events
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StArmed = 2'b01,
        StHold  = 2'b10,
        StLock  = 2'b11
    } state_e;

    // Width wide enough for hold_events plus up to CHANNELS entries in one edge.
    localparam int unsigned SumW  = $clog2(CHANNELS + 1);
    localparam int unsigned WideW = CNT_W + SumW + 1;
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [HOLD_W-1:0] HoldLoad = HOLD_W'(HOLD_CYCLES - 1);

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [HOLD_W-1:0]   cnt_q   [CHANNELS];
    logic [HOLD_W-1:0]   cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] enter;
    logic [SumW-1:0]     enter_cnt;
    logic [WideW-1:0]    sum_wide;
    logic [CNT_W-1:0]    hold_events_q;
    logic [CNT_W-1:0]    hold_events_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= StIdle;
                cnt_q[c]   <= '0;
            end
            hold_events_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            hold_events_q <= hold_events_d;
        end
    end

    // Next-state logic, per channel
    always_comb begin
        enter = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            unique case (state_q[c])
                StIdle: begin
                    if (I[c] && !S[c]) state_d[c] = StArmed;
                end
                StArmed: begin
                    if (!I[c]) begin
                        state_d[c] = StIdle;
                    end else if (S[c]) begin
                        state_d[c] = StHold;
                        cnt_d[c]   = HoldLoad;
                        enter[c]   = 1'b1;
                    end
                end
                StHold: begin
                    if (cnt_q[c] != '0) begin
                        cnt_d[c] = cnt_q[c] - HOLD_W'(1);
                    end else begin
                        state_d[c] = S[c] ? StLock : StIdle;
                    end
                end
                StLock: begin
                    if (!I[c] && !S[c]) state_d[c] = StIdle;
                end
                default: state_d[c] = StIdle;
            endcase
            // Clear discards whatever this edge would have done.
            if (clear) begin
                state_d[c] = StIdle;
                cnt_d[c]   = '0;
                enter[c]   = 1'b0;
            end
        end
    end

    // Shared saturating event counter
    always_comb begin
        enter_cnt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            enter_cnt = enter_cnt + SumW'(enter[c]);
        end
        sum_wide = WideW'(hold_events_q) + WideW'(enter_cnt);
        if (clear) begin
            hold_events_d = '0;
        end else if (sum_wide > WideW'(CntMax)) begin
            hold_events_d = CntMax;
        end else begin
            hold_events_d = sum_wide[CNT_W-1:0];
        end
    end

    // Mealy outputs
    always_comb begin
        B1      = '0;
        B2      = '0;
        state_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            state_o[2*c +: 2] = state_q[c];
            unique case (state_q[c])
                StIdle: begin
                    B1[c] = I[c] & ~S[c];
                end
                StArmed: begin
                    B1[c] = I[c];
                    B2[c] = I[c] & S[c];
                end
                StHold: begin
                    B2[c] = 1'b1;
                end
                StLock: begin
                    B1[c] = 1'b0;
                end
                default: begin
                    B1[c] = 1'b0;
                end
            endcase
        end
    end

    assign hold_events = hold_events_q;

endmodule

// File: tb/tb_mealy_ctrl_multi.sv
module tb_mealy_ctrl_multi;

    localparam int unsigned CHANNELS    = 4;
    localparam int unsigned HOLD_CYCLES = 3;
    localparam int unsigned HOLD_W      = 4;
    localparam int unsigned CNT_W       = 3;

    logic                  clk;
    logic                  reset;
    logic                  clear;
    logic [CHANNELS-1:0]   I;
    logic [CHANNELS-1:0]   S;
    logic [CHANNELS-1:0]   B1;
    logic [CHANNELS-1:0]   B2;
    logic [2*CHANNELS-1:0] state_o;
    logic [CNT_W-1:0]      hold_events;

    int checks = 0;
    int errors = 0;

    mealy_ctrl_multi #(
        .CHANNELS    (CHANNELS),
        .HOLD_CYCLES (HOLD_CYCLES),
        .HOLD_W      (HOLD_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .I           (I),
        .S           (S),
        .B1          (B1),
        .B2          (B2),
        .state_o     (state_o),
        .hold_events (hold_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        I     = 4'b1111;
        S     = 4'b0000;
        step();
        check("rst_b1", 32'(B1), 32'hf);
        check("rst_b2", 32'(B2), 32'h0);
        check("rst_state", 32'(state_o), 32'h0);
        check("rst_events", 32'(hold_events), 32'h0);
        reset = 1'b0;
        step();
        check("armed_all_state", 32'(state_o), 32'h55);
        check("armed_all_b1", 32'(B1), 32'hf);

        // Back to IDLE everywhere
        I = 4'b0000;
        step();
        check("idle_all_state", 32'(state_o), 32'h0);

        // Channel 0: hold then lock
        I = 4'b0001; S = 4'b0000;
        #1 check("c0_idle_b1", 32'(B1), 32'h1);
        step();
        check("c0_armed_state", 32'(state_o), 32'h01);
        S = 4'b0001;
        #1 check("c0_armed_b2", 32'(B2), 32'h1);
        check("c0_armed_b1", 32'(B1), 32'h1);
        step();
        check("c0_hold1_state", 32'(state_o), 32'h02);
        check("c0_hold1_b2", 32'(B2), 32'h1);
        check("c0_hold1_b1", 32'(B1), 32'h0);
        check("c0_hold1_events", 32'(hold_events), 32'h1);
        step();
        check("c0_hold2_b2", 32'(B2), 32'h1);
        step();
        check("c0_hold3_b2", 32'(B2), 32'h1);
        check("c0_hold3_state", 32'(state_o), 32'h02);
        step();
        check("c0_lock_state", 32'(state_o), 32'h03);
        check("c0_lock_b2", 32'(B2), 32'h0);
        check("c0_lock_events", 32'(hold_events), 32'h1);
        I = 4'b0000; S = 4'b0000;
        step();
        check("c0_unlock_state", 32'(state_o), 32'h0);

        // Channel 0: S drops during HOLD, exits to IDLE
        I = 4'b0001; S = 4'b0000;
        step();
        S = 4'b0001;
        #1 check("c0b_armed_b2", 32'(B2), 32'h1);
        step();
        S = 4'b0000;
        #1 check("c0b_hold1_b2", 32'(B2), 32'h1);
        step();
        check("c0b_hold2_b2", 32'(B2), 32'h1);
        step();
        check("c0b_hold3_b2", 32'(B2), 32'h1);
        step();
        check("c0b_exit_state", 32'(state_o), 32'h0);
        check("c0b_exit_b2", 32'(B2), 32'h0);
        check("c0b_exit_b1", 32'(B1), 32'h1);
        check("c0b_events", 32'(hold_events), 32'h2);
        I = 4'b0000;

        // Clear, then all channels enter HOLD twice; count saturates
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_events", 32'(hold_events), 32'h0);
        check("clr_state", 32'(state_o), 32'h0);
        I = 4'b1111; S = 4'b0000;
        step();
        S = 4'b1111;
        step();
        check("all_hold_state", 32'(state_o), 32'haa);
        check("all_hold_events", 32'(hold_events), 32'h4);
        S = 4'b0000;
        step();
        step();
        step();
        check("all_exit_state", 32'(state_o), 32'h0);
        step();
        check("all_rearm_state", 32'(state_o), 32'h55);
        S = 4'b1111;
        step();
        check("sat_events", 32'(hold_events), 32'h7);
        check("sat_state", 32'(state_o), 32'haa);

        // Clear on the ARMED->HOLD edge
        I = 4'b0000; S = 4'b0000;
        step();
        step();
        step();
        check("clr2_pre_state", 32'(state_o), 32'h0);
        I = 4'b1111;
        step();
        S = 4'b1111;
        clear = 1'b1;
        #1 check("clr2_cycle_b2", 32'(B2), 32'hf);
        step();
        clear = 1'b0;
        check("clr2_state", 32'(state_o), 32'h0);
        check("clr2_events", 32'(hold_events), 32'h0);
        check("clr2_b2", 32'(B2), 32'h0);

        // Reset pulsed mid-HOLD
        S = 4'b0000;
        step();
        S = 4'b1111;
        step();
        check("rst2_hold_b2", 32'(B2), 32'hf);
        check("rst2_hold_events", 32'(hold_events), 32'h4);
        #1 reset = 1'b1;
        #1 check("rst2_b2", 32'(B2), 32'h0);
        check("rst2_state", 32'(state_o), 32'h0);
        check("rst2_events", 32'(hold_events), 32'h0);
        check("rst2_b1", 32'(B1), 32'h0);
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mealy_ctrl_multi.md
# mealy_ctrl_multi

Parametrised multi-channel Mealy controller; successor to the single-channel I/S → B1/B2 output-logic block. Each of CHANNELS independent channels runs a four-state Mealy machine: B1/B2 are combinational in current state and inputs, and B2 is stretched by a programmable hold counter. A shared saturating counter tallies hold entries across all channels. It sits between synchronised I/S inputs and the downstream B1/B2 consumers.

## Interface
Parameters:
- CHANNELS, 4: number of independent channels (≥1).
- HOLD_CYCLES, 5: cycles spent in HOLD (≥1, ≤2^HOLD_W).
- HOLD_W, 4: width of the per-channel hold counter.
- CNT_W, 8: width of the event counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; all state to reset values immediately.
- clear  in  1  synchronous clear; priority over all transitions.
- I  in  CHANNELS  per-channel input I.
- S  in  CHANNELS  per-channel input S.
- B1  out  CHANNELS  per-channel Mealy output B1 (combinational).
- B2  out  CHANNELS  per-channel Mealy output B2 (combinational).
- state_o  out  2*CHANNELS  channel c state at [2c+1:2c].
- hold_events  out  CNT_W  saturating count of ARMED→HOLD transitions, all channels.

## Operation
- State encoding: IDLE=00, ARMED=01, HOLD=10, LOCK=11. Below, I and S refer to channel c bits.
- IDLE: B1=I&~S, B2=0. I=1,S=0 → ARMED; otherwise stay.
- ARMED: B1=I, B2=I&S. I=0 → IDLE; I=1,S=1 → HOLD with hold counter loaded to HOLD_CYCLES-1; I=1,S=0 → stay.
- HOLD: B1=0, B2=1 (I/S ignored for outputs). If counter≠0: decrement, stay. If counter=0: S=1 → LOCK, S=0 → IDLE.
- LOCK: B1=0, B2=0. I=0,S=0 → IDLE; otherwise stay.
- Channels are fully independent; no cross-channel interaction except hold_events.
- hold_events: each edge adds the number of channels taking ARMED→HOLD in that cycle (0..CHANNELS); result clamps at 2^CNT_W-1 and never wraps.
- clear=1 at an edge: all channels → IDLE, hold counters → 0, hold_events → 0. Transitions that would have occurred on that edge are discarded and not counted. Outputs during the clear cycle still follow the current state.
- Reset values: all states IDLE, hold counters 0, hold_events 0, state_o all 0. During reset, B1=I&~S and B2=0 per channel (IDLE Mealy outputs).

## Timing
- B1/B2: zero latency, purely combinational from state and I/S; no glitch filtering.
- State, hold counter and hold_events update on the rising edge of clk only (except asynchronous reset).
- Hold stretch: B2 is high in the ARMED cycle where I&S=1, then for exactly HOLD_CYCLES cycles in HOLD, giving HOLD_CYCLES+1 consecutive high cycles.
- The HOLD exit decision samples S on the edge where the counter is 0.
- hold_events is visible the cycle after the entering edge.
- Reset asserted mid-HOLD: channel is IDLE and B2 is 0 immediately, without waiting for a clock; no count is retained.

## Test plan
Use CHANNELS=4, HOLD_CYCLES=3, CNT_W=3.
- Reset with I=4'b1111, S=4'b0000 → B1=4'b1111, B2=0, state_o=0, hold_events=0. After one edge with reset released, state_o=8'b01010101.
- Channel 0: I=1,S=0 for 1 cycle, then I=1,S=1 held → B2[0] high for exactly 4 consecutive cycles, then state LOCK (11). Releasing I=S=0 → IDLE next edge. hold_events=1.
- Same as above, but S drops to 0 while in HOLD → B2[0] stays high through HOLD, then IDLE (not LOCK).
- All 4 channels take ARMED→HOLD on the same edge, twice in succession → hold_events 4, then saturates at 7.
- clear asserted on the ARMED→HOLD edge → all channels IDLE and hold_events=0 next cycle. Separately, reset pulsed mid-HOLD → B2 drops to 0 combinationally before the next edge.
